// File: rtl/move_log.sv
// move_log: records the search engine's move sequence as a packed 2-bit
// stack (newest move at ord[1:0]), handles backtracking pops, optionally
// cancels immediate inverse moves, and freezes the log on success.
//
// Handshake: push/pop/done/fail are single-cycle qualifiers sampled on
// every rising edge while in SEARCH; there is no back-pressure, so any
// combination of them is accepted every cycle with a 1-cycle latency.
module move_log #(
   parameter int MAX_MOVES  = 20,
   parameter int CANCEL_INV = 1
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start,
   input  logic                   mv_push,
   input  logic                   mv_pop,
   input  logic [1:0]             mv_dir,
   input  logic                   done,
   input  logic                   fail,
   output logic                   comp,
   output logic [39:0]            cnt,
   output logic [2*MAX_MOVES-1:0] ord,
   output logic                   busy,
   output logic                   ovf
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SEARCH = 2'd1,
      DONE   = 2'd2,
      FAIL   = 2'd3
   } state_t;

   localparam logic [39:0] MAX_CNT = 40'(MAX_MOVES);

   // Current FSM state; kept as a named signal so checkers can bind to it.
   state_t state;

   logic not_empty;
   logic full;
   logic inverse;

   // Per-cycle stack conditions derived from the current log.
   always_comb begin
      not_empty = (cnt != 40'd0);
      full      = (cnt == MAX_CNT);
      inverse   = (CANCEL_INV != 0) && not_empty && (mv_dir == (ord[1:0] ^ 2'b01));
   end

   // FSM, stack update and all registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         comp  <= 1'b0;
         cnt   <= 40'd0;
         ord   <= '0;
         busy  <= 1'b0;
         ovf   <= 1'b0;
      end else if (start) begin
         // start wins over everything else in the same cycle
         state <= SEARCH;
         comp  <= 1'b0;
         cnt   <= 40'd0;
         ord   <= '0;
         busy  <= 1'b1;
         ovf   <= 1'b0;
      end else begin
         case (state)
            SEARCH: begin
               // Stack operation first, so a move in the done cycle is kept.
               if (mv_push && mv_pop) begin
                  if (not_empty) begin
                     ord[1:0] <= mv_dir;
                  end else begin
                     ord <= {ord[2*MAX_MOVES-3:0], mv_dir};
                     cnt <= cnt + 40'd1;
                  end
               end else if (mv_push) begin
                  if (inverse) begin
                     ord <= ord >> 2;
                     cnt <= cnt - 40'd1;
                  end else if (full) begin
                     ovf <= 1'b1;
                  end else begin
                     ord <= {ord[2*MAX_MOVES-3:0], mv_dir};
                     cnt <= cnt + 40'd1;
                  end
               end else if (mv_pop) begin
                  if (not_empty) begin
                     ord <= ord >> 2;
                     cnt <= cnt - 40'd1;
                  end
               end

               if (done) begin
                  state <= DONE;
                  comp  <= 1'b1;
                  busy  <= 1'b0;
               end else if (fail) begin
                  state <= FAIL;
                  busy  <= 1'b0;
               end
            end
            // IDLE, DONE and FAIL hold until start or reset.
            default: begin
               state <= state;
            end
         endcase
      end
   end

endmodule
